// File: rtl/code_rd_responder.sv
// Code-memory read responder: accepts addresses, issues single-cycle memory reads and
// returns in-order responses through a small buffer. Optional macro: CODE_RD_RANGE_CHECK_EN.
module code_rd_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 256,
  parameter int ADDR_W     = 16,
  parameter int CODE_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_addr_valid_i,
  output logic              rd_addr_ready_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [CODE_W-1:0] mem_rdata_i,
  output logic [CODE_W-1:0] rd_data_o,
  output logic              rd_err_o,
  output logic              rd_data_valid_o,
  input  logic              rd_data_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [CODE_W-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0]     rptr;
  logic [PW-1:0]     wptr;
  logic [CW-1:0]     count;
  logic              infl;
  logic              accept;
  logic              pop;

  // Credit check counts the in-flight read so a returning word always has a free slot.
  assign rd_addr_ready_o = !rst_i && ((count + CW'(infl)) < CW'(FIFO_DEPTH));
  assign accept          = rd_addr_valid_i && rd_addr_ready_o;
  assign mem_addr_o      = rd_addr_i;
  assign rd_data_valid_o = (count != '0);
  assign pop             = rd_data_valid_o && rd_data_ready_i;
  assign rd_data_o       = rd_data_valid_o ? data_mem[rptr] : '0;

`ifdef CODE_RD_RANGE_CHECK_EN
  logic err_mem [FIFO_DEPTH];
  logic infl_err;
  logic addr_err;

  assign addr_err  = {1'b0, rd_addr_i} >= (ADDR_W + 1)'(MEM_WORDS);
  assign mem_req_o = accept && !addr_err;
  assign rd_err_o  = rd_data_valid_o && err_mem[rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      infl_err <= 1'b0;
    end else begin
      infl_err <= accept && addr_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (infl) begin
      data_mem[wptr] <= infl_err ? '0 : mem_rdata_i;
      err_mem[wptr]  <= infl_err;
    end
  end
`else
  assign mem_req_o = accept;
  assign rd_err_o  = 1'b0;

  always_ff @(posedge clk_i) begin
    if (infl) begin
      data_mem[wptr] <= mem_rdata_i;
    end
  end
`endif

  // Clearing the in-flight flag on reset drops any read data still returning from memory.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      infl  <= 1'b0;
    end else begin
      infl  <= accept;
      count <= count + CW'(infl) - CW'(pop);
      if (infl) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_code_rd_responder.sv
// Self-checking bench for code_rd_responder: directed scenarios plus random traffic
// compared against a queue-based transaction model with a two-cycle latency rule.
module tb_code_rd_responder;

  localparam int FIFO_DEPTH = 4;
  localparam int MEM_WORDS  = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rdAddr = '0;
  logic        rdAddrValid = 1'b0;
  logic        rdAddrReady;
  logic        memReq;
  logic [15:0] memAddr;
  logic [31:0] memRdata = '0;
  logic [31:0] rdData;
  logic        rdErr;
  logic        rdDataValid;
  logic        rdDataReady = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } expEntry_t;

  expEntry_t expQ[$];

  always #5 clk = ~clk;

  code_rd_responder #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (16),
    .CODE_W    (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rd_addr_i      (rdAddr),
    .rd_addr_valid_i(rdAddrValid),
    .rd_addr_ready_o(rdAddrReady),
    .mem_req_o      (memReq),
    .mem_addr_o     (memAddr),
    .mem_rdata_i    (memRdata),
    .rd_data_o      (rdData),
    .rd_err_o       (rdErr),
    .rd_data_valid_o(rdDataValid),
    .rd_data_ready_i(rdDataReady)
  );

  function automatic logic [31:0] codeOf(input logic [15:0] a);
    if (a == 16'h0010) return 32'h0000_00A5;
    return {a ^ 16'hC35A, a};
  endfunction

  function automatic logic expErrOf(input logic [15:0] a);
`ifdef CODE_RD_RANGE_CHECK_EN
    return int'(a) >= MEM_WORDS;
`else
    return 1'b0;
`endif
  endfunction

  // Synchronous code memory: data for a strobed address appears one cycle later, noise otherwise.
  always @(posedge clk) begin
    memRdata <= memReq ? codeOf(memAddr) : $urandom();
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic dr, input logic r);
    logic      accept;
    logic      validExp;
    expEntry_t e;
    @(negedge clk);
    rdAddrValid = v;
    rdAddr      = a;
    rdDataReady = dr;
    rst         = r;
    #1;
    if (r) begin
      checkOutput("ready_in_reset", rdAddrReady, 1'b0);
      checkOutput("mem_req_in_reset", memReq, 1'b0);
    end else begin
      checkOutput("addr_ready", rdAddrReady, expQ.size() < FIFO_DEPTH);
      accept = v && rdAddrReady;
      e.err  = expErrOf(a);
      e.data = e.err ? 32'h0 : codeOf(a);
      e.cyc  = cyc;
      checkOutput("mem_req", memReq, accept && !e.err);
      if (accept && !e.err) checkOutput("mem_addr", memAddr, a);
      validExp = (expQ.size() > 0) && (expQ[0].cyc + 2 <= cyc);
      checkOutput("data_valid", rdDataValid, validExp);
      if (validExp) begin
        checkOutput("rd_data", rdData, expQ[0].data);
        checkOutput("rd_err", rdErr, expQ[0].err);
        if (dr) void'(expQ.pop_front());
      end else begin
        checkOutput("idle_data", rdData, 32'h0);
        checkOutput("idle_err", rdErr, 1'b0);
      end
      if (accept) expQ.push_back(e);
    end
    @(posedge clk);
    cyc++;
    if (r) expQ.delete();
  endtask

  initial begin
    $display("[TB] start");
    // Single read of 0x10
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

    // Streaming 0..7
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

    // Backpressure, release, resume
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(32 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

    // Out-of-range address
    applyStimulus(1'b1, 16'd300, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

    // Mid-operation reset with two buffered and one in flight
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(1 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0077, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

    // Full buffer with one read in flight, single-cycle pop
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'(80 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0060, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

    // Random traffic including occasional resets and out-of-range addresses
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0),
                    16'($urandom_range(0, 400)),
                    1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 59) == 0));
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
